ssd_scan_ctrl: RTL
==================

Name: ssd_scan_ctrl

Overview:
Parametrised N-digit seven-segment scan controller, the successor to the fixed two-digit scan logic in the top level. It latches a packed hex display word through a double buffer and commits it only at frame boundaries, so the display never tears. It time-multiplexes the anodes with a programmable dwell period and an anti-ghost blanking interval. It sits between game/status logic and the board An*/Ca..Cg/Dp pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8)
DWELL_CYCLES, 100000, clk cycles each digit is lit
BLANK_CYCLES, 500, clk cycles all anodes are off between digits (0 allowed = no blank state)
CNT_W, 17, width of the dwell/blank counter; must hold max(DWELL_CYCLES, BLANK_CYCLES)-1

Ports:
clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
digits_in  in  4*NUM_DIGITS  hex nibbles; digit i = digits_in[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  1 = digit shown, 0 = slot kept but anode off
load  in  1  single-cycle strobe capturing digits_in/dp_in/digit_en into the pending buffer
update_pending  out  1  pending buffer not yet committed
An  out  NUM_DIGITS  anodes, active-low
Cath  out  7  {Ca..Cg}, active-low
Dp  out  1  decimal point, active-low
scan_idx  out  clog2(NUM_DIGITS) (min 1)  index of the current digit slot
frame_tick  out  1  one-cycle pulse when the last slot completes

Behaviour:
- Reset (async assert, sync-safe release): An all 1, Cath 7'b1111111, Dp 1, scan_idx 0, frame_tick 0, update_pending 0; active and pending buffers all 0 (digit_en 0, so the display is dark); state DISPLAY; counter 0.
- FSM: DISPLAY -> (counter == DWELL_CYCLES-1) -> BLANK, or directly to the next slot if BLANK_CYCLES == 0. BLANK -> (counter == BLANK_CYCLES-1) -> DISPLAY of the next slot. The counter clears on each transition.
- Slot advance: scan_idx increments. After NUM_DIGITS-1 it wraps to 0 and frame_tick pulses for exactly one cycle.
- Disabled digits still consume their full slot time, which keeps brightness uniform.
- Outputs are registered, so pins reflect the state and index with 1 clk latency.
- In DISPLAY with digit_en[idx]=1: An[idx]=0, all other anodes 1; Cath = hex decode of the active nibble; Dp = ~dp[idx].
- In BLANK, or with digit_en[idx]=0: An all 1, Cath all 1, Dp 1.
- Hex decode, active-low {a..g}:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Double buffer:
  - load writes the pending buffer and sets update_pending the next cycle.
  - On a frame wrap with update_pending=1, pending copies to active and update_pending clears. Slot 0 of the new frame shows the new data.
  - A repeated load before commit overwrites pending; last write wins.
  - load in the same cycle as a wrap: the load data goes straight to active, and update_pending stays or becomes 0.
- A reset asserted mid-frame returns to the reset state immediately and discards pending data.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: scanning from the highest enabled digit downward, digits whose active nibble is 0 are treated as disabled, up to the first nonzero nibble. Digit 0 is never suppressed. Suppression is evaluated on the active buffer at commit time and stored as a mask.
- Undefined: zeros are displayed normally and no mask logic is present.

Decomposition:
- Package ssd_pkg holds:
  - the 16-entry segment constant table (active-low)
  - SEG_OFF = 7'b1111111
  - the scan state enum {DISPLAY, BLANK}
  - a clog2-style width function for scan_idx
- Sub-module ssd_hex_decoder: 4-bit nibble in, 7-bit active-low segments out, combinational, from the package table.

Test Plan:
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset release, no load -> An=4'b1111 and Cath=7'b1111111 throughout. frame_tick pulses every 24 cycles; scan_idx sequence 0,1,2,3.
- load digits_in=16'h12AF, digit_en=4'hF, dp_in=4'b0100 -> update_pending=1 until the next wrap. Next frame:
  - slot0: An=1110, Cath=0111000 (F)
  - slot1: An=1101, Cath=0001000 (A)
  - slot2: An=1011, Cath=0010010 (2), Dp=0
  - slot3: An=0111, Cath=1001111 (1)
  - each lit for 4 cycles, with 2 dark cycles between slots.
- Two loads (16'h1111 then 16'h2222) before a wrap -> only 2222 is ever displayed.
- load coincident with frame_tick -> update_pending stays 0 and new data appears in slot 0 on the following cycle.
- digit_en=4'b1011 -> the slot2 window is dark and slot timing is unchanged (frame still 24 cycles).
- Reset_n pulsed low during slot 2 -> outputs go dark asynchronously. After release the controller restarts at scan_idx 0 with the display dark.
- With LEADING_ZERO_BLANK_EN defined: value 16'h0050 shows only digits 1 and 0; value 16'h0000 shows only digit 0 as "0".

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment table,
// blank pattern, scan states and the scan index width helper.
package ssd_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {a..g}, indexed by nibble value (entry 0 in the low bits)
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    typedef enum logic {
        DISPLAY,
        BLANK
    } scan_state_t;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller with frame-synchronous double buffer.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits at commit time.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 17
) (
    input  logic                             clk,
    input  logic                             Reset_n,
    input  logic [4*NUM_DIGITS-1:0]          digits_in,
    input  logic [NUM_DIGITS-1:0]            dp_in,
    input  logic [NUM_DIGITS-1:0]            digit_en,
    input  logic                             load,
    output logic                             update_pending,
    output logic [NUM_DIGITS-1:0]            An,
    output logic [6:0]                       Cath,
    output logic                             Dp,
    output logic [idx_width(NUM_DIGITS)-1:0] scan_idx,
    output logic                             frame_tick
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

    scan_state_t             state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    advance, wrap, commit;

    logic [4*NUM_DIGITS-1:0] act_digits, pend_digits, src_digits;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp, src_dp;
    logic [NUM_DIGITS-1:0]   act_en, pend_en, src_en;
    logic [NUM_DIGITS-1:0]   show_en;
    logic [3:0]              act_nib [NUM_DIGITS];
    logic [6:0]              cur_seg;
    logic                    lit;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= DISPLAY;
            cnt      <= '0;
            scan_idx <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            scan_idx <= idx_nxt;
        end
    end

    // A slot ends after its dwell, or after the blank gap when one is configured
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        advance   = 1'b0;
        case (state)
            DISPLAY: if (cnt == DWELL_LAST) begin
                cnt_nxt = '0;
                if (HAS_BLANK) state_nxt = BLANK;
                else           advance   = 1'b1;
            end
            BLANK: if (cnt == BLANK_LAST) begin
                cnt_nxt   = '0;
                state_nxt = DISPLAY;
                advance   = 1'b1;
            end
        endcase
        wrap    = advance && (scan_idx == LAST_IDX);
        idx_nxt = scan_idx;
        if (advance) idx_nxt = wrap ? '0 : scan_idx + IDX_W'(1);
    end

    assign frame_tick = wrap;

    // A load on the wrap cycle bypasses the pending buffer
    assign commit     = wrap && (load || update_pending);
    assign src_digits = load ? digits_in : pend_digits;
    assign src_dp     = load ? dp_in     : pend_dp;
    assign src_en     = load ? digit_en  : pend_en;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_en        <= '0;
            act_digits     <= '0;
            act_dp         <= '0;
            act_en         <= '0;
            update_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_en     <= digit_en;
            end
            if (commit) begin
                act_digits <= src_digits;
                act_dp     <= src_dp;
                act_en     <= src_en;
            end
            if (wrap)      update_pending <= 1'b0;
            else if (load) update_pending <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask, lz_mask_nxt;
    logic                  leading;

    // Walk down from the top, skipping disabled slots; digit 0 always survives
    always_comb begin
        lz_mask_nxt = '0;
        leading     = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && src_en[i]) begin
                if (src_digits[4*i +: 4] == 4'h0) lz_mask_nxt[i] = 1'b1;
                else                              leading        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n)    lz_mask <= '0;
        else if (commit) lz_mask <= lz_mask_nxt;
    end

    assign show_en = act_en & ~lz_mask;
`else
    assign show_en = act_en;
`endif

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) act_nib[i] = act_digits[4*i +: 4];
    end

    assign lit = (state == DISPLAY) && show_en[scan_idx];

    ssd_hex_decoder u_dec (
        .nibble (act_nib[scan_idx]),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            An   <= '1;
            Cath <= SEG_OFF;
            Dp   <= 1'b1;
        end else begin
            An   <= lit ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
            Cath <= lit ? cur_seg : SEG_OFF;
            Dp   <= lit ? ~act_dp[scan_idx] : 1'b1;
        end
    end

endmodule
